// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 field constants, word geometry and the serial halving FSM state type.
package secp256k1_pkg;

    localparam int unsigned WordWidth = 32;
    localparam int unsigned WordCount = 8;
    localparam int unsigned IdxWidth  = 3;

    localparam logic [31:0] P0 = 32'hFFFFFC2F;
    localparam logic [31:0] P1 = 32'hFFFFFFFE;
    localparam logic [31:0] P2 = 32'hFFFFFFFF;
    localparam logic [31:0] P3 = 32'hFFFFFFFF;
    localparam logic [31:0] P4 = 32'hFFFFFFFF;
    localparam logic [31:0] P5 = 32'hFFFFFFFF;
    localparam logic [31:0] P6 = 32'hFFFFFFFF;
    localparam logic [31:0] P7 = 32'hFFFFFFFF;

    localparam logic [255:0] P = {P7, P6, P5, P4, P3, P2, P1, P0};

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StShift,
        StDone
    } half_state_e;

    function automatic logic [WordWidth-1:0] p_word(input logic [IdxWidth-1:0] idx);
        case (idx)
            3'd0:    p_word = P0;
            3'd1:    p_word = P1;
            default: p_word = 32'hFFFFFFFF;
        endcase
    endfunction

endpackage

// File: rtl/secp256k1_half_mod_serial_if.sv
// Request/response bundle for the serial modular halving unit.
interface secp256k1_half_mod_serial_if;

    logic         start;
    logic [255:0] a;
    logic [255:0] result;
    logic         done;
    logic         busy;

    modport master (
        output start,
        output a,
        input  result,
        input  done,
        input  busy
    );

    modport slave (
        input  start,
        input  a,
        output result,
        output done,
        output busy
    );

endinterface

// File: rtl/secp256k1_word_adc.sv
// Combinational 32-bit add-with-carry slice shared by the serial field datapaths.
module secp256k1_word_adc
    import secp256k1_pkg::*;
(
    input  logic [WordWidth-1:0] x_i,
    input  logic [WordWidth-1:0] y_i,
    input  logic                 cin_i,
    output logic [WordWidth-1:0] sum_o,
    output logic                 cout_o
);

    assign {cout_o, sum_o} = {1'b0, x_i} + {1'b0, y_i} + {{WordWidth{1'b0}}, cin_i};

endmodule

// File: rtl/secp256k1_half_mod_serial.sv
// Serial a/2 mod p: word-serial conditional add of p, then word-serial right shift from the top.
module secp256k1_half_mod_serial
    import secp256k1_pkg::*;
(
    input logic                          clk,
    input logic                          rst_n,
    secp256k1_half_mod_serial_if.slave   bus
);

    half_state_e                               state_q, state_d;
    logic [WordCount-1:0][WordWidth-1:0]       w_q, w_d;
    logic                                      c_q, c_d;
    logic                                      s_q, s_d;
    logic                                      odd_q, odd_d;
    logic [IdxWidth-1:0]                       idx_q, idx_d;
    logic [255:0]                              result_q, result_d;
    logic                                      done_q, done_d;

    logic [WordWidth-1:0] adc_y;
    logic [WordWidth-1:0] adc_sum;
    logic                 adc_cout;

    // Always add (p or 0) so the cycle count never depends on the operand.
    assign adc_y = odd_q ? p_word(idx_q) : '0;

    secp256k1_word_adc u_adc (
        .x_i    (w_q[idx_q]),
        .y_i    (adc_y),
        .cin_i  (c_q),
        .sum_o  (adc_sum),
        .cout_o (adc_cout)
    );

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        c_d      = c_q;
        s_d      = s_q;
        odd_d    = odd_q;
        idx_d    = idx_q;
        result_d = result_q;
        done_d   = done_q;

        case (state_q)
            StIdle: begin
                done_d = 1'b0;
                if (bus.start) begin
                    w_d     = bus.a;
                    odd_d   = bus.a[0];
                    c_d     = 1'b0;
                    idx_d   = '0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                w_d[idx_q] = adc_sum;
                c_d        = adc_cout;
                if (idx_q == 3'd7) begin
                    // Final carry is bit 256 of the sum and enters the shift as the new MSB.
                    s_d     = adc_cout;
                    state_d = StShift;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            StShift: begin
                w_d[idx_q] = {s_q, w_q[idx_q][WordWidth-1:1]};
                s_d        = w_q[idx_q][0];
                if (idx_q == 3'd0) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            StDone: begin
                result_d = w_q;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            w_q      <= '0;
            c_q      <= 1'b0;
            s_q      <= 1'b0;
            odd_q    <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            c_q      <= c_d;
            s_q      <= s_d;
            odd_q    <= odd_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q != StIdle);

endmodule

// File: tb/tb_secp256k1_half_mod_serial.sv
// Self-checking bench for secp256k1_half_mod_serial against a multiply-by-inverse-of-two model.
module tb_secp256k1_half_mod_serial;
    import secp256k1_pkg::*;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    secp256k1_half_mod_serial_if bus_if ();

    secp256k1_half_mod_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a * ((p+1)/2) mod p, using wide integer arithmetic.
    function automatic logic [255:0] ref_half(input logic [255:0] x);
        logic [511:0] pw;
        logic [511:0] inv2;
        logic [511:0] prod;
        pw   = {256'b0, P};
        inv2 = (pw + 512'd1) >> 1;
        prod = {256'b0, x} * inv2;
        prod = prod % pw;
        return prod[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rand_below_p();
        logic [255:0] r;
        r = rand256();
        if (r >= P) r = r - P;
        return r;
    endfunction

    // Issues one request, scrambles a after acceptance, waits for done (bounded).
    task automatic do_op(input logic [255:0] av, output logic [255:0] res, output int lat,
                         output int busy_n);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a     = av;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.a     = rand256();
        busy_n = bus_if.busy ? 1 : 0;
        lat    = -1;
        res    = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.done) begin
                lat = i;
                res = bus_if.result;
                break;
            end
            if (bus_if.busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.start = 1'b0;
        bus_if.a = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus_if.result !== 256'd0 || bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: result=%h done=%b busy=%b, required 0/0/0",
                     bus_if.result, bus_if.done, bus_if.busy);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: done=%b busy=%b, required 0/0",
                     bus_if.done, bus_if.busy);
        end
    endtask

    task automatic test_directed();
        logic [255:0] av [5];
        logic [255:0] ev [5];
        logic [255:0] res;
        int lat;
        int busy_n;
        av[0] = 256'd0;     ev[0] = 256'd0;
        av[1] = 256'd2;     ev[1] = 256'd1;
        av[2] = 256'd1;     ev[2] = {32'h7FFFFFFF, {6{32'hFFFFFFFF}}, 32'h7FFFFE18};
        av[3] = P - 256'd1; ev[3] = {32'h7FFFFFFF, {6{32'hFFFFFFFF}}, 32'h7FFFFE17};
        av[4] = P - 256'd2; ev[4] = P - 256'd1;
        for (int i = 0; i < 5; i++) begin
            do_op(av[i], res, lat, busy_n);
            tests_run++;
            if (res !== ev[i]) begin
                tests_failed++;
                $display("FAIL directed_%0d: result=%h required=%h", i, res, ev[i]);
            end
            tests_run++;
            if (lat != 17 || busy_n != 17) begin
                tests_failed++;
                $display("FAIL directed_timing_%0d: latency=%0d busy_edges=%0d required 17/17",
                         i, lat, busy_n);
            end
        end
    endtask

    task automatic test_random();
        logic [255:0] av;
        logic [255:0] res;
        logic [256:0] dbl;
        int lat;
        int busy_n;
        for (int n = 0; n < 2000; n++) begin
            av = rand_below_p();
            do_op(av, res, lat, busy_n);
            tests_run++;
            if (res !== ref_half(av) || lat != 17) begin
                tests_failed++;
                $display("FAIL random_%0d: a=%h result=%h latency=%0d required=%h latency 17",
                         n, av, res, lat, ref_half(av));
            end
            dbl = {res, 1'b0};
            if (dbl >= {1'b0, P}) dbl = dbl - {1'b0, P};
            tests_run++;
            if (dbl[255:0] !== av || res >= P) begin
                tests_failed++;
                $display("FAIL random_inverse_%0d: 2*result mod p=%h required=%h", n,
                         dbl[255:0], av);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] av;
        int done_e [3];
        int nd;
        av = rand_below_p();
        nd = 0;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a     = av;
        for (int e = 0; e <= 70; e++) begin
            @(posedge clk);
            #1;
            if (bus_if.done && nd < 3) begin
                done_e[nd] = e;
                nd++;
                tests_run++;
                if (bus_if.result !== ref_half(av)) begin
                    tests_failed++;
                    $display("FAIL b2b_result: result=%h required=%h", bus_if.result,
                             ref_half(av));
                end
            end
        end
        bus_if.start = 1'b0;
        repeat (25) @(posedge clk);
        tests_run++;
        if (nd != 3 || done_e[0] != 17 || done_e[1] != 35 || done_e[2] != 53) begin
            tests_failed++;
            $display("FAIL b2b_interval: dones=%0d edges=%0d,%0d,%0d required 3 at 17,35,53",
                     nd, done_e[0], done_e[1], done_e[2]);
        end
    endtask

    task automatic test_start_ignored();
        logic [255:0] av;
        logic [255:0] res;
        int first;
        int nd;
        av    = rand_below_p();
        first = -1;
        nd    = 0;
        res   = '0;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a     = av;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) begin
                bus_if.start = 1'b1;
                bus_if.a     = rand_below_p();
            end
            if (i == 5) bus_if.start = 1'b0;
            if (bus_if.done) begin
                if (first < 0) begin
                    first = i;
                    res   = bus_if.result;
                end
                nd++;
            end
        end
        tests_run++;
        if (nd != 1 || first != 17 || res !== ref_half(av) || bus_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_ignored: dones=%0d first=%0d result=%h busy=%b, required 1 at 17 result=%h busy=0",
                     nd, first, res, bus_if.busy, ref_half(av));
        end
    endtask

    task automatic test_reset_abort();
        logic [255:0] av;
        logic [255:0] res;
        int nd;
        int lat;
        int busy_n;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a     = rand_below_p();
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus_if.result !== 256'd0 || bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_state: result=%h done=%b busy=%b, required 0/0/0",
                     bus_if.result, bus_if.done, bus_if.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.done || bus_if.busy) nd++;
        end
        tests_run++;
        if (nd != 0) begin
            tests_failed++;
            $display("FAIL abort_quiet: done/busy seen %0d cycles, required 0", nd);
        end
        av = rand_below_p() | 256'd1;
        do_op(av, res, lat, busy_n);
        tests_run++;
        if (res !== ref_half(av) || lat != 17) begin
            tests_failed++;
            $display("FAIL abort_recover: result=%h latency=%0d required=%h latency 17",
                     res, lat, ref_half(av));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
